// File: rtl/video_pkg.sv
// Shared types and constants for the video source scheduler slice.
//   vsched_state_t : scheduler FSM states (live/colour, each with a pending variant)
//   MODE_*         : encodings of the 2-bit source mode input
package video_pkg;

  typedef enum logic [1:0] {
    ST_LIVE        = 2'b00,
    ST_LIVE_PEND   = 2'b01,
    ST_COLOUR      = 2'b10,
    ST_COLOUR_PEND = 2'b11
  } vsched_state_t;

  localparam logic [1:0] MODE_LIVE   = 2'b00;
  localparam logic [1:0] MODE_COLOUR = 2'b01;
  localparam logic [1:0] MODE_AUTO   = 2'b10;
  localparam logic [1:0] MODE_MANUAL = 2'b11;

endpackage

// File: rtl/video_src_sched_if.sv
// Control/status bundle of the video source scheduler.
//   mode_i      : source mode (force live / force colour / auto / manual)
//   req_i       : manual toggle request
//   vid_sel_o   : selected source, 0 = live, 1 = colour
//   pend_o      : switch wanted but not yet taken
//   switch_o    : one-clk pulse after a switch
//   frame_cnt_o : free-running frame tick counter
// slave = the scheduler, master = whoever drives the mode/request.
interface video_src_sched_if #(
  parameter int unsigned FCNT_W = 16
);
  logic [1:0]        mode_i;
  logic              req_i;
  logic              vid_sel_o;
  logic              pend_o;
  logic              switch_o;
  logic [FCNT_W-1:0] frame_cnt_o;

  modport slave (
    input  mode_i, req_i,
    output vid_sel_o, pend_o, switch_o, frame_cnt_o
  );

  modport master (
    output mode_i, req_i,
    input  vid_sel_o, pend_o, switch_o, frame_cnt_o
  );
endinterface

// File: rtl/video_frame_tick.sv
// Frame tick generator: rising edge of Vblank seen on clock-enabled cycles.
//   clk_i    : video clock
//   rst_ni   : async active-low reset
//   cen_i    : video clock enable
//   vblank_i : vertical blanking
//   tick_o   : one cen cycle high at the start of Vblank
module video_frame_tick (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cen_i,
  input  logic vblank_i,
  output logic tick_o
);
  logic vblank_d;

  // Resets high so a reset released inside Vblank does not look like an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    vblank_d <= 1'b1;
    else if (cen_i) vblank_d <= vblank_i;
  end

  assign tick_o = cen_i & vblank_i & ~vblank_d;
endmodule

// File: rtl/video_src_sched.sv
// Frame-synchronous live/colour source scheduler. Switches only at the start
// of Vblank, honours a minimum dwell between switches.
//   clk_i, rst_ni, cen_i : video clock, async active-low reset, clock enable
//   vh_blank_i           : {Vblank, Hblank}; only Vblank is used
//   sched                : mode/request in, selection/pending/switch/frame count out
module video_src_sched
  import video_pkg::*;
#(
  parameter int unsigned FRAME_W     = 8,
  parameter int unsigned AUTO_FRAMES = 60,
  parameter int unsigned MIN_DWELL   = 2,
  parameter int unsigned FCNT_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cen_i,
  input  logic [1:0]           vh_blank_i,
  video_src_sched_if.slave     sched
);
  localparam logic [FRAME_W-1:0] AUTO_TH  = FRAME_W'(AUTO_FRAMES - 1);
  localparam logic [FRAME_W-1:0] DWELL_TH = FRAME_W'(MIN_DWELL - 1);

  vsched_state_t     state, state_n;
  logic              tick, want, take, sel, pend;
  logic [FRAME_W-1:0] dwell;
  logic              req_lat;
  logic              switch_q;
  logic [FCNT_W-1:0] fcnt;
  logic              unused_hblank;

  assign unused_hblank = vh_blank_i[0];

  video_frame_tick u_tick (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .cen_i    (cen_i),
    .vblank_i (vh_blank_i[1]),
    .tick_o   (tick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_LIVE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    sel     = (state == ST_COLOUR) || (state == ST_COLOUR_PEND);
    pend    = (state == ST_LIVE_PEND) || (state == ST_COLOUR_PEND);
    unique case (sched.mode_i)
      MODE_LIVE:   want = sel;
      MODE_COLOUR: want = ~sel;
      MODE_AUTO:   want = (dwell >= AUTO_TH);
      default:     want = req_lat | sched.req_i;
    endcase
    // tick already carries cen_i, so take is a single-clk event
    take = tick & want & (dwell >= DWELL_TH);
    if (cen_i) begin
      if (take) begin
        state_n = sel ? ST_LIVE : ST_COLOUR;
      end else begin
        unique case (state)
          ST_LIVE:        if (want)  state_n = ST_LIVE_PEND;
          ST_COLOUR:      if (want)  state_n = ST_COLOUR_PEND;
          ST_LIVE_PEND:   if (!want) state_n = ST_LIVE;
          ST_COLOUR_PEND: if (!want) state_n = ST_COLOUR;
          default:                   state_n = ST_LIVE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dwell    <= '0;
      req_lat  <= 1'b0;
      switch_q <= 1'b0;
      fcnt     <= '0;
    end else begin
      switch_q <= take;
      if (cen_i) begin
        if (take)                dwell <= '0;
        else if (tick && dwell != '1) dwell <= dwell + 1'b1;

        if (sched.mode_i != MODE_MANUAL || take) req_lat <= 1'b0;
        else if (sched.req_i)                    req_lat <= 1'b1;

        if (tick) fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign sched.vid_sel_o   = sel;
  assign sched.pend_o      = pend;
  assign sched.switch_o    = switch_q;
  assign sched.frame_cnt_o = fcnt;
endmodule

// File: tb/tb_video_src_sched.sv
module tb_video_src_sched;
  localparam int AUTO = 4;
  localparam int MIND = 2;
  localparam int FCW  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic [1:0] vh_blank = 2'b10;

  video_src_sched_if #(.FCNT_W(FCW)) vif ();

  video_src_sched #(
    .FRAME_W     (8),
    .AUTO_FRAMES (AUTO),
    .MIN_DWELL   (MIND),
    .FCNT_W      (FCW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cen_i      (cen),
    .vh_blank_i (vh_blank),
    .sched      (vif)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  // reference model: selected source, pending flag, switch pulse, counters
  logic m_sel, m_pend, m_sw, m_vbd, m_rlat;
  int   m_dwell, m_fcnt, m_switches;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_rst();
    m_sel = 0; m_pend = 0; m_sw = 0; m_vbd = 1; m_rlat = 0;
    m_dwell = 0; m_fcnt = 0;
  endtask

  task automatic check_all();
    check_val("vid_sel", vif.vid_sel_o, m_sel);
    check_val("pend", vif.pend_o, m_pend);
    check_val("switch", vif.switch_o, m_sw);
    check_val("fcnt", vif.frame_cnt_o, m_fcnt);
  endtask

  // one clock: drive inputs, advance model by the behavioural rules, compare
  task automatic cyc(input logic c, input logic vb, input logic [1:0] m, input logic r);
    logic tick, want, take;
    cen = c; vh_blank = {vb, 1'($urandom)}; vif.mode_i = m; vif.req_i = r;
    if (!rst_n) model_rst();
    else if (c) begin
      tick = vb && !m_vbd;
      m_vbd = vb;
      case (m)
        2'd0:    want = m_sel;
        2'd1:    want = !m_sel;
        2'd2:    want = (m_dwell >= AUTO - 1);
        default: want = m_rlat || r;
      endcase
      take = tick && want && (m_dwell >= MIND - 1);
      if (take) begin
        m_sel = !m_sel; m_dwell = 0; m_switches++;
      end else if (tick) m_dwell = (m_dwell < 255) ? m_dwell + 1 : 255;
      if (m != 2'd3 || take) m_rlat = 0;
      else if (r) m_rlat = 1;
      m_pend = take ? 1'b0 : want;
      m_sw = take;
      if (tick) m_fcnt = (m_fcnt + 1) % (1 << FCW);
    end else m_sw = 0;
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset(input logic vb);
    rst_n = 1'b0;
    #1;
    model_rst();
    check_val("rst_vid_sel", vif.vid_sel_o, 1'b0);
    check_val("rst_pend", vif.pend_o, 1'b0);
    check_val("rst_switch", vif.switch_o, 1'b0);
    check_val("rst_fcnt", vif.frame_cnt_o, 0);
    repeat (2) cyc(1'b1, vb, 2'd0, 1'b0);
    rst_n = 1'b1;
  endtask

  // n frames with cen held high: 3 active cycles then 2 Vblank cycles
  task automatic vframes(input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) begin
      repeat (3) cyc(1'b1, 1'b0, m, 1'b0);
      repeat (2) cyc(1'b1, 1'b1, m, 1'b0);
    end
  endtask

  initial begin
    int   run;
    logic vb_r, alt;
    logic [1:0] mode_r;
    vif.mode_i = 2'd0; vif.req_i = 1'b0;
    m_switches = 0;
    #2;

    // reset released inside Vblank: no tick
    do_reset(1'b1);
    repeat (4) cyc(1'b1, 1'b1, 2'd0, 1'b0);
    check_val("midvb_fcnt", vif.frame_cnt_o, 0);
    check_val("midvb_sel", vif.vid_sel_o, 1'b0);

    // force colour: switch lands on the second tick
    do_reset(1'b0);
    cyc(1'b1, 1'b0, 2'd1, 1'b0);
    check_val("f1_pend_early", vif.pend_o, 1'b1);
    vframes(1, 2'd1);
    check_val("f1_after_tick1", vif.vid_sel_o, 1'b0);
    vframes(2, 2'd1);
    check_val("f1_sel", vif.vid_sel_o, 1'b1);

    // auto alternate, 12 ticks then on through the 4-bit wrap
    do_reset(1'b0);
    vframes(12, 2'd2);
    check_val("auto_fcnt12", vif.frame_cnt_o, 12);
    check_val("auto_sel12", vif.vid_sel_o, 1'b1);
    vframes(6, 2'd2);
    check_val("auto_wrap", vif.frame_cnt_o, 2);

    // manual: three requests before one Vblank give one toggle
    do_reset(1'b0);
    vframes(2, 2'd3);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 2'd3, 1'b1);
      cyc(1'b1, 1'b0, 2'd3, 1'b0);
    end
    repeat (2) cyc(1'b1, 1'b1, 2'd3, 1'b0);
    check_val("man_one_toggle", vif.vid_sel_o, 1'b1);
    check_val("man_pend_clr", vif.pend_o, 1'b0);
    vframes(1, 2'd3);
    repeat (3) cyc(1'b1, 1'b0, 2'd3, 1'b0);
    cyc(1'b1, 1'b1, 2'd3, 1'b1);
    check_val("man_req_on_tick", vif.vid_sel_o, 1'b0);
    cyc(1'b1, 1'b1, 2'd3, 1'b0);

    // mode cancel before the tick
    do_reset(1'b0);
    vframes(2, 2'd0);
    cyc(1'b1, 1'b0, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 1'b0);
    vframes(1, 2'd0);
    check_val("cancel_sel", vif.vid_sel_o, 1'b0);

    // reset while pending back to live aborts and drops the selection
    do_reset(1'b0);
    vframes(3, 2'd1);
    cyc(1'b1, 1'b0, 2'd0, 1'b0);
    check_val("pre_rst_pend", vif.pend_o, 1'b1);
    do_reset(1'b0);

    // randomized: phases of 1-of-2 cen and random cen
    vb_r = 1'b0; run = 3; alt = 1'b0; mode_r = 2'd3;
    m_switches = 0;
    for (int k = 0; k < 4000; k++) begin
      logic c;
      if (run == 0) begin
        vb_r = ~vb_r;
        run = vb_r ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 8));
      end
      alt = ~alt;
      c = ((k / 500) % 2 == 0) ? alt : ($urandom_range(0, 3) != 0);
      if (c) run--;
      if ($urandom_range(0, 59) == 0) mode_r = 2'($urandom);
      cyc(c, vb_r, mode_r, $urandom_range(0, 5) == 0);
    end
    if (m_switches == 0) check_val("rand_saw_switches", 0, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
